// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with an in-order response queue feeding decode.
// Define FETCH_PERF_EN to add the saturating flush/bubble performance counters.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4_out
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_flush_cnt,
    output logic [15:0] perf_bubble_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    cnt_t        count, count_n;
    cnt_t        inflight, inflight_n;
    cnt_t        drop_cnt, drop_cnt_n;
    ptr_t        rd_ptr, wr_ptr;

    logic [31:0] q_instr [DEPTH];
    logic [31:0] q_pc    [DEPTH];

    logic        accept;
    logic        rsp_keep;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    logic        room;
    logic [CW:0] occupancy;
    logic [31:0] oldest_pc;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign occupancy = {1'b0, inflight} + {1'b0, count};
    assign room      = occupancy < (CW + 1)'(DEPTH);

    assign imem_req_valid = !RST && !redirect_valid && room;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // Current-epoch requests are consecutive words, so the oldest one in flight
    // sits inflight words behind fetch_pc; this replaces a separate PC FIFO.
    assign oldest_pc = fetch_pc - 32'({inflight, 2'b00});

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = imem_rsp_valid && (drop_cnt == '0);
    assign push     = rsp_keep && !redirect_valid;

    assign instr_valid  = (count != '0);
    assign pop          = instr_valid && !stall && !redirect_valid;
    assign instr_out    = instr_valid ? q_instr[rd_ptr] : '0;
    assign pc_out       = instr_valid ? q_pc[rd_ptr] : '0;
    assign pc_plus4_out = pc_out + 32'd4;

    always_comb begin
        fetch_pc_n = fetch_pc;
        count_n    = count;
        inflight_n = inflight;
        drop_cnt_n = drop_cnt;
        state_n    = state;

        if (redirect_valid) begin
            fetch_pc_n = {redirect_pc[31:2], 2'b00};
            count_n    = '0;
            inflight_n = '0;
            drop_cnt_n = drop_cnt + inflight - cnt_t'(imem_rsp_valid);
            state_n    = (drop_cnt_n != '0) ? FLUSH : RUN;
        end else begin
            if (accept) begin
                fetch_pc_n = fetch_pc + 32'd4;
            end
            inflight_n = inflight + cnt_t'(accept) - cnt_t'(rsp_keep);
            drop_cnt_n = drop_cnt - cnt_t'(rsp_drop);
            count_n    = count + cnt_t'(push) - cnt_t'(pop);
            case (state)
                RUN:     state_n = RUN;
                FLUSH:   state_n = (drop_cnt_n == '0) ? RUN : FLUSH;
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            count    <= count_n;
            inflight <= inflight_n;
            drop_cnt <= drop_cnt_n;
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + ptr_t'(1);
                if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            q_instr[wr_ptr] <= imem_rsp_data;
            q_pc[wr_ptr]    <= oldest_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_flush_cnt  <= '0;
            perf_bubble_cnt <= '0;
        end else begin
            if (redirect_valid && perf_flush_cnt != '1) begin
                perf_flush_cnt <= perf_flush_cnt + 16'd1;
            end
            if (!instr_valid && !redirect_valid && perf_bubble_cnt != '1) begin
                perf_bubble_cnt <= perf_bubble_cnt + 16'd1;
            end
        end
    end
`endif

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        (push && !pop) |-> (count < cnt_t'(DEPTH)));

    a_rsp_has_owner: assert property (@(posedge CLK) disable iff (RST)
        rsp_keep |-> (inflight != '0));

    a_drop_bounded: assert property (@(posedge CLK) disable iff (RST)
        drop_cnt <= cnt_t'(DEPTH));

    a_state_tracks_drop: assert property (@(posedge CLK) disable iff (RST)
        (state == FLUSH) == (drop_cnt != '0));

    a_req_held: assert property (@(posedge CLK) disable iff (RST)
        (imem_req_valid && !imem_req_ready) |=>
            (redirect_valid || (imem_req_valid && $stable(imem_req_addr))));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table, corner sequences and a
// randomized run against an epoch-tagged memory/queue reference model.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_flush_cnt;
    logic [15:0] perf_bubble_cnt;
`endif

    always #5 CLK = ~CLK;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .pc_plus4_out   (pc_plus4_out)
`ifdef FETCH_PERF_EN
        ,
        .perf_flush_cnt (perf_flush_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          st;
        bit          rv;
        logic [31:0] addr;
        bit          iv;
        logic [31:0] pc;
    } vec_t;

    mreq_t       mem_q[$];
    ent_t        exp_q[$];
    int unsigned epoch, cyc, last_due, lat_min, lat_max;
    logic [31:0] m_fetch_pc;
    bit          rnd_ready;
    int          checks, errors;
    int unsigned m_flush, m_bubble;

    bit          g_st, g_rd, g_do_rsp, g_acc, g_exp_iv;
    logic [31:0] g_rpc;

    function automatic logic [31:0] memword(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    function automatic int unsigned cur_inflight();
        int unsigned n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch == epoch) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the negedge and compare outputs to the model.
    task automatic apply(input bit st, input bit rd, input logic [31:0] rpc);
        bit exp_rv;
        g_st = st; g_rd = rd; g_rpc = rpc;
        stall          = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        g_do_rsp       = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid = g_do_rsp;
        imem_rsp_data  = g_do_rsp ? memword(mem_q[0].addr) : $urandom;
        #1;
        g_exp_iv = exp_q.size() > 0;
        chk("instr_valid", 32'(instr_valid), 32'(g_exp_iv));
        if (g_exp_iv) begin
            chk("pc_out", pc_out, exp_q[0].pc);
            chk("instr_out", instr_out, exp_q[0].data);
            chk("pc_plus4_out", pc_plus4_out, exp_q[0].pc + 32'd4);
        end
        exp_rv = !rd && ((cur_inflight() + exp_q.size()) < DEPTH);
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("req_addr", imem_req_addr, m_fetch_pc);
        g_acc = exp_rv && imem_req_ready;
    endtask

    task automatic advance();
        mreq_t       head;
        mreq_t       nr;
        int unsigned due;
        @(posedge CLK);
        if (g_rd) begin
            if (m_flush < 16'hFFFF) m_flush++;
        end else if (!g_exp_iv) begin
            if (m_bubble < 16'hFFFF) m_bubble++;
        end
        if (g_do_rsp) head = mem_q.pop_front();
        if (g_rd) begin
            exp_q.delete();
            m_fetch_pc = {g_rpc[31:2], 2'b00};
            epoch++;
        end else begin
            if (g_exp_iv && !g_st) void'(exp_q.pop_front());
            if (g_do_rsp && head.epoch == epoch) exp_q.push_back('{pc: head.addr, data: memword(head.addr)});
            if (g_acc) begin
                due = cyc + $urandom_range(lat_min, lat_max);
                if (due < last_due) due = last_due;
                last_due = due;
                nr = '{addr: m_fetch_pc, epoch: epoch, due: due};
                mem_q.push_back(nr);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        cyc++;
        @(negedge CLK);
    endtask

    task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
        apply(st, rd, rpc);
        advance();
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall          = 1'b0;
        #1;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_pc_plus4", pc_plus4_out, 32'd4);
`ifdef FETCH_PERF_EN
        chk("rst_perf_flush", 32'(perf_flush_cnt), 32'd0);
        chk("rst_perf_bubble", 32'(perf_bubble_cnt), 32'd0);
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        mem_q.delete();
        exp_q.delete();
        m_fetch_pc = RESET_PC;
        last_due   = 0;
        m_flush    = 0;
        m_bubble   = 0;
    endtask

    vec_t        tbl[6];
    logic [31:0] wrap_exp[3];
    logic [31:0] first_pc;
    bit          seen;

    initial begin
        checks = 0; errors = 0; epoch = 0; cyc = 0;
        rnd_ready = 1'b0; lat_min = 1; lat_max = 1;

        // Startup with 1-cycle memory: fetch-to-decode is one cycle after the response.
        tbl[0] = '{st: 1'b0, rv: 1'b1, addr: 32'd0,  iv: 1'b0, pc: 32'd0};
        tbl[1] = '{st: 1'b0, rv: 1'b1, addr: 32'd4,  iv: 1'b0, pc: 32'd0};
        tbl[2] = '{st: 1'b0, rv: 1'b1, addr: 32'd8,  iv: 1'b1, pc: 32'd0};
        tbl[3] = '{st: 1'b0, rv: 1'b1, addr: 32'd12, iv: 1'b1, pc: 32'd4};
        tbl[4] = '{st: 1'b0, rv: 1'b1, addr: 32'd16, iv: 1'b1, pc: 32'd8};
        tbl[5] = '{st: 1'b1, rv: 1'b1, addr: 32'd20, iv: 1'b1, pc: 32'd12};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i].st, 1'b0, '0);
            chk("tbl_req_valid", 32'(imem_req_valid), 32'(tbl[i].rv));
            chk("tbl_req_addr", imem_req_addr, tbl[i].addr);
            chk("tbl_instr_valid", 32'(instr_valid), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk("tbl_pc_out", pc_out, tbl[i].pc);
                chk("tbl_pc_plus4", pc_plus4_out, tbl[i].pc + 32'd4);
            end
            advance();
        end

        // Long stall: capacity fills, requests stop, then four back-to-back pops.
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, '0);
        apply(1'b1, 1'b0, '0);
        chk("stall_req_blocked", 32'(imem_req_valid), 32'd0);
        chk("stall_buffered", 32'(exp_q.size()), 32'(DEPTH));
        advance();
        first_pc = pc_out;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b0, '0);
            chk("drain_valid", 32'(instr_valid), 32'd1);
            chk("drain_pc", pc_out, first_pc + 32'(4 * i));
            advance();
        end

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat_min = 3; lat_max = 3;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0103);
        apply(1'b0, 1'b0, '0);
        chk("redir_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_req_addr", imem_req_addr, 32'h0000_0100);
        chk("redir_no_instr", 32'(instr_valid), 32'd0);
        advance();
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            apply(1'b0, 1'b0, '0);
            if (instr_valid) begin
                seen = 1'b1;
                chk("redir_first_pc", pc_out, 32'h0000_0100);
            end
            advance();
        end
        chk("redir_first_seen", 32'(seen), 32'd1);

        // Redirect coinciding with a response and a dequeue (2-cycle memory).
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h0000_0200);
        apply(1'b0, 1'b0, '0);
        chk("redir_rsp_empty", 32'(instr_valid), 32'd0);
        chk("redir_rsp_addr", imem_req_addr, 32'h0000_0200);
        advance();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0);

        // Back-to-back redirects: the later target wins.
        cycle(1'b0, 1'b1, 32'h0000_0300);
        cycle(1'b0, 1'b1, 32'h0000_0406);
        apply(1'b0, 1'b0, '0);
        chk("b2b_req_addr", imem_req_addr, 32'h0000_0404);
        advance();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0);

        // Address wrap at the top of the 32-bit space.
        lat_min = 1; lat_max = 1;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, '0);
            chk("wrap_req_addr", imem_req_addr, wrap_exp[i]);
            advance();
        end
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            apply(1'b0, 1'b0, '0);
            if (instr_valid && pc_out == 32'hFFFF_FFFC) begin
                seen = 1'b1;
                chk("wrap_pc_plus4", pc_plus4_out, 32'h0000_0000);
            end
            advance();
        end
        chk("wrap_seen", 32'(seen), 32'd1);

`ifdef FETCH_PERF_EN
        chk("perf_flush", 32'(perf_flush_cnt), 32'(m_flush));
        chk("perf_bubble", 32'(perf_bubble_cnt), 32'(m_bubble));
`endif

        // Randomized traffic with an asynchronous reset in the middle.
        rnd_ready = 1'b1; lat_min = 1; lat_max = DEPTH;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 4, $urandom);
        end

`ifdef FETCH_PERF_EN
        chk("perf_flush_end", 32'(perf_flush_cnt), 32'(m_flush));
        chk("perf_bubble_end", 32'(perf_bubble_cnt), 32'(m_bubble));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage that sits directly upstream of the decode pipeline register of the RISC-V core.
- Issues sequential word fetches to instruction memory over a request/response handshake and buffers the returned instructions, with their PC, in a small in-order queue.
- Presents one instruction per cycle to decode and honours a decode-side stall.
- On a taken-branch redirect, flushes all buffered and in-flight fetches and restarts at the target PC.

Parameters:
- DEPTH, 4, queue entries; also the maximum of in-flight requests plus buffered entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response data valid; responses return in request order, latency ≥1.
- imem_rsp_data  input  32  fetched instruction.
- redirect_valid  input  1  branch taken (PCSrcM); flush and restart.
- redirect_pc  input  32  branch target (PCBranchM); bits [1:0] ignored and forced 0.
- stall  input  1  decode cannot accept this cycle.
- instr_valid  output  1  instr_out/pc_out hold a valid instruction.
- instr_out  output  32  instruction at the queue head.
- pc_out  output  32  PC of the head instruction.
- pc_plus4_out  output  32  pc_out + 4, modulo 2^32.

Behaviour:
- Reset (async):
  - fetch_pc = RESET_PC; queue empty; inflight = 0; drop_cnt = 0.
  - instr_valid = 0, imem_req_valid = 0, instr_out = 0, pc_out = 0, pc_plus4_out = 4.
  - Reset asserted mid-operation discards everything; responses arriving after reset release are not tracked.
- Request issue:
  - imem_req_valid = !RST && !redirect_valid && (inflight + count < DEPTH).
  - imem_req_addr = fetch_pc.
  - On accept (valid && ready): fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), inflight += 1.
  - A request is never withdrawn or changed while valid and not ready.
- Response:
  - If drop_cnt > 0: the response is discarded and drop_cnt -= 1.
  - Otherwise it is enqueued with the PC from the in-order PC shadow of the oldest in-flight request. Each response decrements inflight.
  - Overflow cannot occur by construction; an assertion is required.
- Dequeue:
  - instr_valid = (count > 0).
  - The head pops when instr_valid && !stall.
  - Empty and enqueue in the same cycle: the data appears the next cycle (no bypass; fetch-to-decode latency is 1 cycle after the response).
  - Enqueue and dequeue in the same cycle when full or non-empty: count is unchanged.
- Redirect (priority over everything in that cycle):
  - Queue cleared; count = 0; fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt_next = drop_cnt + inflight − (response this cycle).
  - inflight is treated as stale: it is tracked via drop_cnt, and the inflight counter is set to 0 for new-epoch accounting.
  - No request is issued in the redirect cycle; the first target fetch is issued the following cycle.
  - instr_valid is 0 the cycle after a redirect.
  - Back-to-back redirects: the last one wins, and drop_cnt accumulates correctly.
- State machine: 2 states.
  - RUN: normal operation.
  - FLUSH: entered on redirect when drop_cnt_next > 0; new requests are still issued while draining, since accounting is by count.
  - Exit FLUSH to RUN when drop_cnt reaches 0.
  - The state is exposed only internally and via assertions.
- Widths: count and inflight are $clog2(DEPTH)+1 bits; drop_cnt is $clog2(DEPTH)+1 bits and never exceeds DEPTH.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs perf_flush_cnt [15:0] (redirects accepted) and perf_bubble_cnt [15:0] (cycles with !instr_valid && !redirect_valid).
  - Both counters saturate at 16'hFFFF and reset to 0 on RST.
- Undefined: the ports and logic are absent, and there is no functional difference otherwise.

Test Plan:
- Reset release, memory with fixed 1-cycle latency, always ready, no stall -> requests at 0,4,8,...; instr_valid first high 2 cycles after the first accept; pc_out sequence 0,4,8; pc_plus4_out = pc_out+4.
- stall held for 10 cycles with DEPTH=4 -> at most 4 buffered + in-flight; imem_req_valid drops to 0; on stall release, 4 instructions pop in consecutive cycles in PC order.
- Memory latency 3, redirect_valid with redirect_pc=32'h0000_0103 while 2 requests are in flight -> both stale responses dropped; next request address 32'h0000_0100; the first instr_valid carries pc_out=32'h100.
- Redirect in the same cycle as a response and a dequeue -> response discarded, queue empty next cycle, drop_cnt equals remaining in-flight count.
- fetch_pc=32'hFFFF_FFF8, no stall -> requests at FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_out for FFFF_FFFC equals 0.
- With FETCH_PERF_EN: 3 redirects and a stall-free stream -> perf_flush_cnt=3; perf_bubble_cnt counts only empty non-redirect cycles; RST asserted mid-stream clears both counters and instr_valid asynchronously.
